// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CPU definitions for precise exception commit: ExcCodes, flush masks,
// controller state encoding and the priority-picker result record.
package exc_commit_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // flush[0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB
  localparam logic [3:0] FLUSH_MEM   = 4'b1111;
  localparam logic [3:0] FLUSH_EX    = 4'b0111;
  localparam logic [3:0] FLUSH_ID    = 4'b0011;
  localparam logic [3:0] FLUSH_DRAIN = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERET = 1'b1
  } kind_e;

  typedef struct packed {
    logic        take;
    kind_e       kind;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badvaddr;
    logic [3:0]  mask;
  } sel_t;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Pipeline/CP0/IF-side signal bundle of the exception commit controller.
interface exc_commit_ctrl_if;
  logic        mem_exc_valid;
  logic [4:0]  mem_exc_code;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic [31:0] mem_badvaddr;
  logic        ex_exc_valid;
  logic [4:0]  ex_exc_code;
  logic [31:0] ex_pc;
  logic        ex_in_ds;
  logic        id_exc_valid;
  logic [4:0]  id_exc_code;
  logic [31:0] id_pc;
  logic        id_in_ds;
  logic [31:0] id_badvaddr;
  logic        int_pending;
  logic        cp0_exl;
  logic [31:0] cp0_epc;
  logic        eret_valid;
  logic        if_ready;

  logic        stall_all;
  logic [3:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_epc_wdata;
  logic        cp0_bd;
  logic        cp0_badvaddr_we;
  logic [31:0] cp0_badvaddr;
  logic        cp0_clr_exl;

  modport master (
    output mem_exc_valid, mem_exc_code, mem_pc, mem_in_ds, mem_badvaddr,
    output ex_exc_valid, ex_exc_code, ex_pc, ex_in_ds,
    output id_exc_valid, id_exc_code, id_pc, id_in_ds, id_badvaddr,
    output int_pending, cp0_exl, cp0_epc, eret_valid, if_ready,
    input  stall_all, flush, redirect_valid, redirect_pc,
    input  cp0_exc_we, cp0_excode, cp0_epc_wdata, cp0_bd,
    input  cp0_badvaddr_we, cp0_badvaddr, cp0_clr_exl
  );

  modport slave (
    input  mem_exc_valid, mem_exc_code, mem_pc, mem_in_ds, mem_badvaddr,
    input  ex_exc_valid, ex_exc_code, ex_pc, ex_in_ds,
    input  id_exc_valid, id_exc_code, id_pc, id_in_ds, id_badvaddr,
    input  int_pending, cp0_exl, cp0_epc, eret_valid, if_ready,
    output stall_all, flush, redirect_valid, redirect_pc,
    output cp0_exc_we, cp0_excode, cp0_epc_wdata, cp0_bd,
    output cp0_badvaddr_we, cp0_badvaddr, cp0_clr_exl
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_sel.sv
// Combinational oldest-first picker over MEM/ERET/EX/ID/interrupt requests.
module exc_prio_sel
  import exc_commit_ctrl_pkg::*;
(
  input  logic        mem_exc_valid,
  input  logic [4:0]  mem_exc_code,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_ds,
  input  logic [31:0] mem_badvaddr,
  input  logic        eret_valid,
  input  logic        ex_exc_valid,
  input  logic [4:0]  ex_exc_code,
  input  logic [31:0] ex_pc,
  input  logic        ex_in_ds,
  input  logic        id_exc_valid,
  input  logic [4:0]  id_exc_code,
  input  logic [31:0] id_pc,
  input  logic        id_in_ds,
  input  logic [31:0] id_badvaddr,
  input  logic        int_pending,
  input  logic        cp0_exl,
  output sel_t        sel
);

  always_comb begin
    sel      = '0;
    sel.kind = KIND_EXC;
    if (mem_exc_valid) begin
      sel.take     = 1'b1;
      sel.code     = mem_exc_code;
      sel.pc       = mem_pc;
      sel.bd       = mem_in_ds;
      sel.badvaddr = mem_badvaddr;
      sel.mask     = FLUSH_MEM;
    end else if (eret_valid) begin
      sel.take = 1'b1;
      sel.kind = KIND_ERET;
      sel.mask = FLUSH_MEM;
    end else if (ex_exc_valid) begin
      sel.take = 1'b1;
      sel.code = ex_exc_code;
      sel.pc   = ex_pc;
      sel.bd   = ex_in_ds;
      sel.mask = FLUSH_EX;
    end else if (id_exc_valid) begin
      sel.take     = 1'b1;
      sel.code     = id_exc_code;
      sel.pc       = id_pc;
      sel.bd       = id_in_ds;
      sel.badvaddr = id_badvaddr;
      sel.mask     = FLUSH_ID;
    end else if (int_pending && !cp0_exl) begin
      // Interrupt rides on the ID instruction, which has not executed yet.
      sel.take = 1'b1;
      sel.code = EXC_INT;
      sel.pc   = id_pc;
      sel.bd   = id_in_ds;
      sel.mask = FLUSH_ID;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Precise exception / ERET commit sequencer: take -> COMMIT -> REDIRECT -> DRAIN.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  exc_commit_ctrl_if.slave bus
);

  sel_t   sel;
  state_e state_q, state_d;

  kind_e       kind_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic        bd_q;
  logic        bva_we_q;
  logic [31:0] bva_q;
  logic [3:0]  mask_q;
  logic [31:0] target_q;

  exc_prio_sel u_sel (
    .mem_exc_valid (bus.mem_exc_valid),
    .mem_exc_code  (bus.mem_exc_code),
    .mem_pc        (bus.mem_pc),
    .mem_in_ds     (bus.mem_in_ds),
    .mem_badvaddr  (bus.mem_badvaddr),
    .eret_valid    (bus.eret_valid),
    .ex_exc_valid  (bus.ex_exc_valid),
    .ex_exc_code   (bus.ex_exc_code),
    .ex_pc         (bus.ex_pc),
    .ex_in_ds      (bus.ex_in_ds),
    .id_exc_valid  (bus.id_exc_valid),
    .id_exc_code   (bus.id_exc_code),
    .id_pc         (bus.id_pc),
    .id_in_ds      (bus.id_in_ds),
    .id_badvaddr   (bus.id_badvaddr),
    .int_pending   (bus.int_pending),
    .cp0_exl       (bus.cp0_exl),
    .sel           (sel)
  );

  wire take = (state_q == ST_IDLE) && sel.take;
  wire take_bva = (sel.kind == KIND_EXC) && is_addr_exc(sel.code);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_EXC;
      code_q   <= '0;
      epc_q    <= '0;
      bd_q     <= 1'b0;
      bva_we_q <= 1'b0;
      bva_q    <= '0;
      mask_q   <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        kind_q   <= sel.kind;
        code_q   <= sel.code;
        // Nested exception under EXL: CP0 keeps the original EPC.
        epc_q    <= bus.cp0_exl ? bus.cp0_epc : epc_of(sel.pc, sel.bd);
        bd_q     <= sel.bd;
        bva_we_q <= take_bva;
        bva_q    <= take_bva ? sel.badvaddr : '0;
        mask_q   <= sel.mask;
        target_q <= (sel.kind == KIND_ERET) ? bus.cp0_epc : EXC_VECTOR;
      end
    end
  end

  logic        stall_all, redirect_valid, cp0_exc_we, cp0_bd;
  logic        cp0_badvaddr_we, cp0_clr_exl;
  logic [3:0]  flush;
  logic [4:0]  cp0_excode;
  logic [31:0] redirect_pc, cp0_epc_wdata, cp0_badvaddr;

  always_comb begin
    state_d         = state_q;
    stall_all       = 1'b0;
    flush           = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    cp0_exc_we      = 1'b0;
    cp0_excode      = '0;
    cp0_epc_wdata   = '0;
    cp0_bd          = 1'b0;
    cp0_badvaddr_we = 1'b0;
    cp0_badvaddr    = '0;
    cp0_clr_exl     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel.take) begin
          stall_all = 1'b1;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        stall_all = 1'b1;
        flush     = mask_q;
        if (kind_q == KIND_ERET) begin
          cp0_clr_exl = 1'b1;
        end else begin
          cp0_exc_we      = 1'b1;
          cp0_excode      = code_q;
          cp0_epc_wdata   = epc_q;
          cp0_bd          = bd_q;
          cp0_badvaddr_we = bva_we_q;
          cp0_badvaddr    = bva_q;
        end
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall_all      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (bus.if_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        flush   = FLUSH_DRAIN;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.stall_all       = stall_all;
  assign bus.flush           = flush;
  assign bus.redirect_valid  = redirect_valid;
  assign bus.redirect_pc     = redirect_pc;
  assign bus.cp0_exc_we      = cp0_exc_we;
  assign bus.cp0_excode      = cp0_excode;
  assign bus.cp0_epc_wdata   = cp0_epc_wdata;
  assign bus.cp0_bd          = cp0_bd;
  assign bus.cp0_badvaddr_we = cp0_badvaddr_we;
  assign bus.cp0_badvaddr    = cp0_badvaddr;
  assign bus.cp0_clr_exl     = cp0_clr_exl;

endmodule
